// File: rtl/trng_arbiter.sv
// rtl/trng_arbiter.sv - round-robin arbiter sharing one trng_reg source among N requesters
// Optional repeated-word rejection is compiled in with TRNG_ARB_REPEAT_CHECK_EN.
module trng_arbiter #(
    parameter int N   = 4,
    parameter int W   = 32,
    parameter int TMO = 4096,
    localparam int IW = $clog2(N),
    localparam int CW = $clog2(TMO)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  rsp_vld,
    output logic [W-1:0]  rsp_data,
    output logic          rsp_err,
    output logic          trng_gen,
    input  logic          trng_rdy,
    input  logic [W-1:0]  trng_rdn,
    output logic          busy,
    output logic [IW-1:0] grant_id,
    output logic          tmo_sticky
);

    typedef enum logic [1:0] {S_IDLE, S_GEN, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] wd_q, wd_d;
    logic [W-1:0]  data_q, data_d;
    logic          err_q, err_d;
    logic          tmo_q, tmo_d;

    logic [IW-1:0] pick;
    logic [IW-1:0] scan;
    logic          found;

`ifdef TRNG_ARB_REPEAT_CHECK_EN
    logic [W-1:0]  last_q, last_d;
    logic          last_vld_q, last_vld_d;
    logic [1:0]    rep_q, rep_d;
`endif

    // Scan upward from the slot after the last winner, wrapping at N-1.
    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        scan  = ptr_q;
        for (int k = 0; k < N; k++) begin
            scan = (scan == IW'(N - 1)) ? '0 : scan + 1'b1;
            if (!found && req[scan]) begin
                pick  = scan;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        wd_d    = wd_q;
        data_d  = data_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
`ifdef TRNG_ARB_REPEAT_CHECK_EN
        last_d     = last_q;
        last_vld_d = last_vld_q;
        rep_d      = rep_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_GEN;
                    grant_d = pick;
                    ptr_d   = pick;
                    wd_d    = '0;
`ifdef TRNG_ARB_REPEAT_CHECK_EN
                    rep_d   = '0;
`endif
                end
            end
            S_GEN: begin
                if (trng_rdy) begin
`ifdef TRNG_ARB_REPEAT_CHECK_EN
                    if (last_vld_q && (trng_rdn == last_q)) begin
                        if (rep_q == 2'd2) begin
                            state_d = S_RESP;
                            err_d   = 1'b1;
                            data_d  = '0;
                        end else begin
                            rep_d = rep_q + 2'd1;
                            wd_d  = '0;
                        end
                    end else begin
                        state_d    = S_RESP;
                        err_d      = 1'b0;
                        data_d     = trng_rdn;
                        last_d     = trng_rdn;
                        last_vld_d = 1'b1;
                        rep_d      = '0;
                    end
`else
                    state_d = S_RESP;
                    err_d   = 1'b0;
                    data_d  = trng_rdn;
`endif
                end else if (wd_q == CW'(TMO - 1)) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                    data_d  = '0;
                    tmo_d   = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ptr_q   <= IW'(N - 1);
            wd_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
            data_q  <= data_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

`ifdef TRNG_ARB_REPEAT_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
            rep_q      <= '0;
        end else begin
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
            rep_q      <= rep_d;
        end
    end
`endif

    // Outputs decode registered state only, so reset clears them at once.
    always_comb begin
        rsp_vld = '0;
        if (state_q == S_RESP) rsp_vld[grant_q] = 1'b1;
    end

    assign rsp_data   = data_q;
    assign rsp_err    = err_q & (state_q == S_RESP);
    assign trng_gen   = (state_q == S_GEN);
    assign busy       = (state_q != S_IDLE);
    assign grant_id   = grant_q;
    assign tmo_sticky = tmo_q;

endmodule

// File: tb/tb_trng_arbiter.sv
// tb/tb_trng_arbiter.sv - self-checking bench for trng_arbiter with a behavioural trng source
module tb_trng_arbiter;
    localparam int N   = 4;
    localparam int W   = 32;
    localparam int TMO = 48;
    localparam int IW  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  rsp_vld;
    logic [W-1:0]  rsp_data;
    logic          rsp_err;
    logic          trng_gen;
    logic          trng_rdy = 1'b0;
    logic [W-1:0]  trng_rdn = '0;
    logic          busy;
    logic [IW-1:0] grant_id;
    logic          tmo_sticky;

    int checks   = 0;
    int failures = 0;
    int mptr     = N - 1;

    int           src_delay  = 1;
    bit           src_en     = 1'b1;
    int           src_cnt    = 0;
    int           src_pulses = 0;
    logic [W-1:0] src_q[$];
    logic [W-1:0] last_rdn   = '0;

    always #5 clk = ~clk;

    trng_arbiter #(.N(N), .W(W), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .rsp_vld(rsp_vld), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .trng_gen(trng_gen), .trng_rdy(trng_rdy), .trng_rdn(trng_rdn),
        .busy(busy), .grant_id(grant_id), .tmo_sticky(tmo_sticky)
    );

    // Source: sees gen, then after src_delay cycles presents one word for one cycle.
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            trng_rdy = 1'b0;
            src_cnt  = 0;
        end else if (trng_rdy) begin
            trng_rdy = 1'b0;
        end else if (src_cnt > 0) begin
            src_cnt = src_cnt - 1;
            if (src_cnt == 0) begin
                trng_rdn = (src_q.size() > 0) ? src_q.pop_front() : W'($urandom);
                last_rdn = trng_rdn;
                trng_rdy = 1'b1;
                src_pulses++;
            end
        end else if (trng_gen && src_en) begin
            src_cnt = src_delay;
        end
    end

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++)
            if (((r >> ((p + k) % N)) & 1) != 0) return (p + k) % N;
        return -1;
    endfunction

    task automatic wait_rsp(output int cyc, output int gen_cyc);
        cyc = 0;
        gen_cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (trng_gen) gen_cyc++;
        end while (rsp_vld == '0 && cyc < 400);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (rsp_vld !== '0) begin failures++; $display("FAIL reset_rsp_vld got=%b exp=0", rsp_vld); end
        checks++; if (rsp_data !== '0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
        checks++; if (trng_gen !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_gen_busy got=%b%b exp=00", trng_gen, busy); end
        checks++; if (grant_id !== '0 || tmo_sticky !== 1'b0 || rsp_err !== 1'b0) begin
            failures++; $display("FAIL reset_misc grant=%0d tmo=%b err=%b exp=0", grant_id, tmo_sticky, rsp_err); end
        rst = 1'b1;
        mptr = N - 1;
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        int order1[4] = '{0, 1, 2, 3};
        int order2[2] = '{0, 3};
        int cyc, gc;
        src_delay = 1;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_rsp(cyc, gc);
            checks++; if (rsp_vld !== N'(1 << order1[i]) || grant_id !== IW'(order1[i])) begin
                failures++; $display("FAIL rr_order[%0d] got vld=%b id=%0d exp id=%0d", i, rsp_vld, grant_id, order1[i]); end
            req[order1[i]] = 1'b0;
            mptr = order1[i];
        end
        @(negedge clk);
        req = 4'b1001;
        for (int i = 0; i < 2; i++) begin
            wait_rsp(cyc, gc);
            checks++; if (rsp_vld !== N'(1 << order2[i])) begin
                failures++; $display("FAIL rr_reraise[%0d] got vld=%b exp id=%0d", i, rsp_vld, order2[i]); end
            req[order2[i]] = 1'b0;
            mptr = order2[i];
        end
        @(negedge clk);
    endtask

    task automatic test_single;
        int cyc, gc;
        src_delay = 1;
        src_q.push_back(32'hDEADBEEF);
        req = 4'b0001;
        wait_rsp(cyc, gc);
        checks++; if (cyc != 3) begin failures++; $display("FAIL single_latency got=%0d exp=3", cyc); end
        checks++; if (gc != 2) begin failures++; $display("FAIL single_gen_cycles got=%0d exp=2", gc); end
        checks++; if (rsp_vld !== 4'b0001) begin failures++; $display("FAIL single_vld got=%b exp=0001", rsp_vld); end
        checks++; if (rsp_data !== 32'hDEADBEEF || rsp_err !== 1'b0) begin
            failures++; $display("FAIL single_data got=%h err=%b exp=deadbeef err=0", rsp_data, rsp_err); end
        req = '0;
        mptr = 0;
        @(negedge clk);
        checks++; if (rsp_vld !== '0 || busy !== 1'b0) begin failures++; $display("FAIL single_one_shot got vld=%b busy=%b exp=0", rsp_vld, busy); end
    endtask

    task automatic test_slow;
        int cyc, gc;
        src_delay = 40;
        req = 4'b0100;
        wait_rsp(cyc, gc);
        checks++; if (gc != 41) begin failures++; $display("FAIL slow_gen_cycles got=%0d exp=41", gc); end
        checks++; if (rsp_vld !== 4'b0100 || rsp_err !== 1'b0 || rsp_data !== last_rdn) begin
            failures++; $display("FAIL slow_rsp got vld=%b err=%b data=%h exp 0100/0/%h", rsp_vld, rsp_err, rsp_data, last_rdn); end
        checks++; if (tmo_sticky !== 1'b0) begin failures++; $display("FAIL slow_tmo got=%b exp=0", tmo_sticky); end
        req = '0;
        mptr = 2;
        src_delay = 1;
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int cyc, gc;
        src_en = 1'b0;
        req = 4'b0010;
        wait_rsp(cyc, gc);
        checks++; if (gc != TMO) begin failures++; $display("FAIL tmo_gen_cycles got=%0d exp=%0d", gc, TMO); end
        checks++; if (rsp_vld !== 4'b0010 || rsp_err !== 1'b1 || rsp_data !== '0) begin
            failures++; $display("FAIL tmo_rsp got vld=%b err=%b data=%h exp 0010/1/0", rsp_vld, rsp_err, rsp_data); end
        checks++; if (tmo_sticky !== 1'b1) begin failures++; $display("FAIL tmo_sticky got=%b exp=1", tmo_sticky); end
        mptr = 1;
        src_en = 1'b1;
        req = 4'b1000;
        wait_rsp(cyc, gc);
        checks++; if (rsp_vld !== 4'b1000 || rsp_err !== 1'b0 || rsp_data !== last_rdn || tmo_sticky !== 1'b1) begin
            failures++; $display("FAIL tmo_recover got vld=%b err=%b data=%h tmo=%b exp 1000/0/%h/1", rsp_vld, rsp_err, rsp_data, tmo_sticky, last_rdn); end
        req = '0;
        mptr = 3;
        @(negedge clk);
    endtask

    task automatic test_no_revoke;
        int cyc, gc;
        req = 4'b0100;
        @(negedge clk);
        checks++; if (trng_gen !== 1'b1 || grant_id !== 2'd2) begin
            failures++; $display("FAIL norevoke_grant got gen=%b id=%0d exp 1/2", trng_gen, grant_id); end
        req = '0;
        wait_rsp(cyc, gc);
        checks++; if (rsp_vld !== 4'b0100 || rsp_err !== 1'b0) begin
            failures++; $display("FAIL norevoke_rsp got vld=%b err=%b exp 0100/0", rsp_vld, rsp_err); end
        mptr = 2;
        @(negedge clk);
    endtask

    task automatic repeat_txn(input logic [W-1:0] w0, input logic [W-1:0] w1, input logic [W-1:0] w2, input int nw,
                              input logic [W-1:0] exp_data, input logic exp_err, input int exp_pulses, input string nm);
        int cyc, gc, p0;
        src_q.push_back(w0);
        if (nw > 1) src_q.push_back(w1);
        if (nw > 2) src_q.push_back(w2);
        p0 = src_pulses;
        req = 4'b0001;
        wait_rsp(cyc, gc);
        checks++; if (rsp_vld !== 4'b0001 || rsp_data !== exp_data || rsp_err !== exp_err || (src_pulses - p0) != exp_pulses) begin
            failures++; $display("FAIL %s got vld=%b data=%h err=%b words=%0d exp 0001/%h/%b/%0d",
                                 nm, rsp_vld, rsp_data, rsp_err, src_pulses - p0, exp_data, exp_err, exp_pulses); end
        req = '0;
        mptr = 0;
        src_q.delete();
        @(negedge clk);
    endtask

    task automatic test_repeat;
        repeat_txn(32'h12345678, '0, '0, 1, 32'h12345678, 1'b0, 1, "rep_first");
`ifdef TRNG_ARB_REPEAT_CHECK_EN
        repeat_txn(32'h12345678, 32'hAAAA5555, '0, 2, 32'hAAAA5555, 1'b0, 2, "rep_discard");
        repeat_txn(32'hAAAA5555, 32'hAAAA5555, 32'hAAAA5555, 3, '0, 1'b1, 3, "rep_third_err");
        repeat_txn(32'hAAAA5555, 32'h0F0F0F0F, '0, 2, 32'h0F0F0F0F, 1'b0, 2, "rep_cnt_regrant");
`else
        repeat_txn(32'h12345678, '0, '0, 1, 32'h12345678, 1'b0, 1, "rep_delivered");
`endif
    endtask

    task automatic test_random;
        int cyc, gc, exp_id, dly;
        req = N'($urandom_range(1, (1 << N) - 1));
        dly = $urandom_range(1, 6);
        src_delay = dly;
        for (int t = 0; t < 30; t++) begin
            exp_id = rr_pick(req, mptr);
            wait_rsp(cyc, gc);
            checks++; if (rsp_vld !== N'(1 << exp_id) || grant_id !== IW'(exp_id)) begin
                failures++; $display("FAIL rand_grant[%0d] got vld=%b id=%0d exp id=%0d", t, rsp_vld, grant_id, exp_id); end
            checks++; if (rsp_data !== last_rdn || rsp_err !== 1'b0 || gc != dly + 1) begin
                failures++; $display("FAIL rand_rsp[%0d] got data=%h err=%b gen=%0d exp %h/0/%0d", t, rsp_data, rsp_err, gc, last_rdn, dly + 1); end
            mptr = exp_id;
            req[exp_id] = 1'b0;
            req = (req & N'($urandom)) | N'($urandom);
            if (req == '0) req = N'(1 << $urandom_range(0, N - 1));
            dly = $urandom_range(1, 6);
            src_delay = dly;
        end
        req = '0;
        src_delay = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int cyc, gc, n;
        src_delay = 30;
        req = 4'b0100;
        n = 0;
        while (!trng_gen && n < 20) begin @(negedge clk); n++; end
        checks++; if (trng_gen !== 1'b1) begin failures++; $display("FAIL rstmid_enter_gen got=%b exp=1", trng_gen); end
        #2 rst = 1'b0;
        #1;
        checks++; if (trng_gen !== 1'b0 || busy !== 1'b0 || rsp_vld !== '0 || tmo_sticky !== 1'b0) begin
            failures++; $display("FAIL rstmid_async got gen=%b busy=%b vld=%b tmo=%b exp 0", trng_gen, busy, rsp_vld, tmo_sticky); end
        req = 4'b1111;
        n = 0;
        repeat (3) begin @(negedge clk); if (rsp_vld != '0) n++; end
        checks++; if (n != 0) begin failures++; $display("FAIL rstmid_no_rsp got=%0d exp=0", n); end
        rst = 1'b1;
        mptr = N - 1;
        src_delay = 1;
        wait_rsp(cyc, gc);
        checks++; if (rsp_vld !== 4'b0001 || rsp_err !== 1'b0) begin
            failures++; $display("FAIL rstmid_prio got vld=%b err=%b exp 0001/0", rsp_vld, rsp_err); end
        req = '0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_slow();
        test_timeout();
        test_no_revoke();
        test_repeat();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
